// File: rtl/arbitro_wrr.sv
// ---------------------------------------------------------------------------
// arbitro_wrr
// Weighted round-robin arbiter moving words from four first-word-fall-through
// input FIFOs (P0..P3) to four output FIFOs, one word per cycle. Each input
// queue receives a turn of up to QUOTAn words. Every word is routed to the
// output FIFO named by its top two bits. A turn ends early when the queue runs
// empty, or when its head word has been blocked by an almost-full destination
// for STALL_MAX consecutive cycles.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   in_empty[3:0]    empty flags of input FIFOs P0..P3
//   fifo_out         head word of the input FIFO selected by sel
//   out_almost_full  almost-full flags of output FIFOs 0..3
//   sel[1:0]         index of the queue being served (held while arbitrating)
//   pop[3:0]         one-hot pop to input FIFOs (combinational)
//   push[3:0]        one-hot push to output FIFOs (registered)
//   data_out         word written to the output FIFOs (registered)
//   words_fwd[7:0]   wrapping count of words pushed
// ---------------------------------------------------------------------------
module arbitro_wrr #(
   parameter int unsigned WORD_W    = 12,
   parameter logic [3:0]  QUOTA0    = 4'd4,
   parameter logic [3:0]  QUOTA1    = 4'd2,
   parameter logic [3:0]  QUOTA2    = 4'd1,
   parameter logic [3:0]  QUOTA3    = 4'd1,
   parameter logic [3:0]  STALL_MAX = 4'd8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        in_empty,
   input  logic [WORD_W-1:0] fifo_out,
   input  logic [3:0]        out_almost_full,
   output logic [1:0]        sel,
   output logic [3:0]        pop,
   output logic [3:0]        push,
   output logic [WORD_W-1:0] data_out,
   output logic [7:0]        words_fwd
);

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_SERVE = 1'b1;

   // Value of stall_cnt on the last tolerated stalled cycle of a turn.
   localparam logic [3:0] STALL_LAST = STALL_MAX - 4'd1;

   // Per-queue turn length; a zero quota still grants one word per turn.
   function automatic logic [3:0] quota_of(input logic [1:0] idx);
      logic [3:0] qv;
      case (idx)
         2'd0:    qv = QUOTA0;
         2'd1:    qv = QUOTA1;
         2'd2:    qv = QUOTA2;
         default: qv = QUOTA3;
      endcase
      return (qv == 4'd0) ? 4'd1 : qv;
   endfunction

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // First non-empty queue at or after start, wrapping; bit 2 flags a hit.
   function automatic logic [2:0] find_next(input logic [3:0] empty,
                                            input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] cand;
      res = {1'b0, start};
      // Scan from farthest to nearest so the nearest hit wins.
      for (int k = 3; k >= 0; k--) begin
         cand = start + 2'(k);
         if (!empty[cand]) begin
            res = {1'b1, cand};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   logic [0:0]        state_r, state_s;
   logic [1:0]        ptr_r, ptr_s;
   logic [1:0]        q_r, q_s;
   logic [3:0]        quota_cnt_r, quota_cnt_s;
   logic [3:0]        stall_cnt_r, stall_cnt_s;
   logic [3:0]        push_r;
   logic [WORD_W-1:0] data_out_r;
   logic [7:0]        words_fwd_r;

   logic [1:0]        dest_s;
   logic [2:0]        search_s;
   logic              pop_en_s;
   logic [3:0]        pop_s;

   assign dest_s   = fifo_out[WORD_W-1 -: 2];
   assign search_s = find_next(in_empty, ptr_r);

   // Next-state and pop decision; priority inside a turn is empty > stall > pop.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      q_s         = q_r;
      quota_cnt_s = quota_cnt_r;
      stall_cnt_s = stall_cnt_r;
      pop_en_s    = 1'b0;
      pop_s       = 4'd0;
      case (state_r)
         ST_ARB: begin
            if (search_s[2]) begin
               q_s         = search_s[1:0];
               quota_cnt_s = quota_of(search_s[1:0]);
               stall_cnt_s = 4'd0;
               state_s     = ST_SERVE;
            end else begin
               state_s     = ST_ARB;
            end
         end
         ST_SERVE: begin
            if (in_empty[q_r]) begin
               state_s = ST_ARB;
               ptr_s   = q_r + 2'd1;
            end else if (out_almost_full[dest_s]) begin
               stall_cnt_s = stall_cnt_r + 4'd1;
               if (stall_cnt_r == STALL_LAST) begin
                  state_s = ST_ARB;
                  ptr_s   = q_r + 2'd1;
               end else begin
                  state_s = ST_SERVE;
               end
            end else begin
               pop_en_s    = 1'b1;
               pop_s       = onehot4(q_r);
               stall_cnt_s = 4'd0;
               quota_cnt_s = quota_cnt_r - 4'd1;
               // A queue emptying on its last-quota pop leaves here, not via the empty rule.
               if (quota_cnt_r <= 4'd1) begin
                  state_s = ST_ARB;
                  ptr_s   = q_r + 2'd1;
               end else begin
                  state_s = ST_SERVE;
               end
            end
         end
         default: begin
            state_s = ST_ARB;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_ARB;
         ptr_r       <= 2'd0;
         q_r         <= 2'd0;
         quota_cnt_r <= 4'd0;
         stall_cnt_r <= 4'd0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         q_r         <= q_s;
         quota_cnt_r <= quota_cnt_s;
         stall_cnt_r <= stall_cnt_s;
      end
   end

   // Output stage: the popped word is pushed to its destination one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         push_r     <= 4'd0;
         data_out_r <= {WORD_W{1'b0}};
      end else if (pop_en_s) begin
         push_r     <= onehot4(dest_s);
         data_out_r <= fifo_out;
      end else begin
         push_r     <= 4'd0;
         data_out_r <= data_out_r;
      end
   end

   // Forwarded-word counter, stepping on each cycle a push is presented.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         words_fwd_r <= 8'd0;
      end else if (push_r != 4'd0) begin
         words_fwd_r <= words_fwd_r + 8'd1;
      end else begin
         words_fwd_r <= words_fwd_r;
      end
   end

   assign sel       = q_r;
   assign pop       = pop_s;
   assign push      = push_r;
   assign data_out  = data_out_r;
   assign words_fwd = words_fwd_r;

endmodule

// File: tb/tb_arbitro_wrr.sv
// ---------------------------------------------------------------------------
// tb_arbitro_wrr
// Self-checking bench for arbitro_wrr. The input FIFOs are modelled as four
// queues; a turn-level reference model predicts pop and sel each cycle and
// pushes the expected output word into a scoreboard, which an independent
// monitor drains whenever the DUT presents its registered outputs.
// ---------------------------------------------------------------------------
module tb_arbitro_wrr;

   localparam int QUOTA[4]  = '{4, 2, 1, 1};
   localparam int STALL_LIM = 8;

   logic        clk;
   logic        reset;
   logic [3:0]  in_empty;
   logic [11:0] fifo_out;
   logic [3:0]  out_almost_full;
   logic [1:0]  sel;
   logic [3:0]  pop;
   logic [3:0]  push;
   logic [11:0] data_out;
   logic [7:0]  words_fwd;

   arbitro_wrr #(
      .WORD_W(12), .QUOTA0(4'd4), .QUOTA1(4'd2), .QUOTA2(4'd1), .QUOTA3(4'd1),
      .STALL_MAX(4'd8)
   ) dut (
      .clk(clk), .reset(reset), .in_empty(in_empty), .fifo_out(fifo_out),
      .out_almost_full(out_almost_full), .sel(sel), .pop(pop), .push(push),
      .data_out(data_out), .words_fwd(words_fwd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- input FIFO contents ----------------
   logic [11:0] q0[$], q1[$], q2[$], q3[$];

   function automatic int qsize(input int i);
      case (i)
         0: return q0.size();
         1: return q1.size();
         2: return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic logic [11:0] qhead(input int i);
      if (qsize(i) == 0) return 12'h000;
      case (i)
         0: return q0[0];
         1: return q1[0];
         2: return q2[0];
         default: return q3[0];
      endcase
   endfunction

   task automatic qpush(input int i, input logic [11:0] w);
      case (i)
         0: q0.push_back(w);
         1: q1.push_back(w);
         2: q2.push_back(w);
         default: q3.push_back(w);
      endcase
   endtask

   task automatic qpop(input int i);
      logic [11:0] w;
      case (i)
         0: w = q0.pop_front();
         1: w = q1.pop_front();
         2: w = q2.pop_front();
         default: w = q3.pop_front();
      endcase
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [3:0]  p;
      logic [11:0] d;
   } exp_t;
   exp_t sb[$];

   // ---------------- stimulus knobs ----------------
   logic [3:0]  keep_mask   = 4'b0000;
   int          rnd_fill    = 0;
   logic        fixed_en    = 1'b0;
   logic [11:0] fixed_word  = 12'h000;
   logic [3:0]  af_fixed    = 4'b0000;
   int          af_pct      = 0;

   // ---------------- reference model ----------------
   bit          m_serve  = 1'b0;
   int          m_owner  = 0;
   int          m_left   = 0;
   int          m_stalls = 0;
   int          m_ptr    = 0;
   logic [1:0]  exp_sel  = 2'd0;

   function automatic logic [11:0] gen_word();
      return fixed_en ? fixed_word : 12'($urandom);
   endfunction

   task automatic drive();
      logic [3:0] af;
      for (int i = 0; i < 4; i++) begin
         if (keep_mask[i] && qsize(i) < 4) qpush(i, gen_word());
         if (qsize(i) < 16 && $urandom_range(99) < rnd_fill) qpush(i, gen_word());
      end
      af = af_fixed;
      for (int b = 0; b < 4; b++) if ($urandom_range(99) < af_pct) af[b] = 1'b1;
      out_almost_full = af;
      for (int i = 0; i < 4; i++) in_empty[i] = (qsize(i) == 0);
      fifo_out = (qsize(int'(sel)) > 0) ? qhead(int'(sel)) : 12'($urandom);
   endtask

   task automatic end_turn();
      m_serve = 1'b0;
      m_ptr   = (m_owner + 1) % 4;
   endtask

   // One cycle of the turn rules, evaluated on the inputs just driven.
   task automatic eval();
      logic [3:0]  ep;
      logic [11:0] w;
      logic [1:0]  d;
      exp_t        e;
      bit          found;
      ep = 4'd0;
      chk("sel", 32'(sel), 32'(exp_sel));
      if (!m_serve) begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (!found && qsize((m_ptr + k) % 4) > 0) begin
               found    = 1'b1;
               m_owner  = (m_ptr + k) % 4;
               m_left   = QUOTA[m_owner];
               m_stalls = 0;
               m_serve  = 1'b1;
               exp_sel  = 2'(m_owner);
            end
         end
      end else if (qsize(m_owner) == 0) begin
         end_turn();
      end else begin
         w = qhead(m_owner);
         d = w[11:10];
         if (out_almost_full[d]) begin
            m_stalls++;
            if (m_stalls == STALL_LIM) end_turn();
         end else begin
            ep[m_owner] = 1'b1;
            qpop(m_owner);
            e.p = 4'd0;
            e.p[d] = 1'b1;
            e.d = w;
            sb.push_back(e);
            m_stalls = 0;
            m_left--;
            if (m_left == 0) end_turn();
         end
      end
      chk("pop", 32'(pop), 32'(ep));
   endtask

   task automatic cycle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         drive();
         #1;
         eval();
      end
   endtask

   task automatic drain();
      int guard;
      keep_mask = 4'b0000; rnd_fill = 0; af_fixed = 4'b0000; af_pct = 0;
      guard = 0;
      while ((qsize(0) + qsize(1) + qsize(2) + qsize(3)) > 0 && guard < 300) begin
         cycle(1);
         guard++;
      end
      cycle(3);
      if (guard >= 300) begin
         n_checks++; n_err++;
         $display("FAIL drain_timeout: got %0d words left expected 0",
                  qsize(0) + qsize(1) + qsize(2) + qsize(3));
      end
   endtask

   task automatic reset_checks();
      chk("rst_pop", 32'(pop), 32'd0);
      chk("rst_push", 32'(push), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_words", 32'(words_fwd), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
   endtask

   task automatic model_reset();
      m_serve = 1'b0; m_ptr = 0; m_owner = 0; m_left = 0; m_stalls = 0;
      exp_sel = 2'd0;
   endtask

   // ---------------- monitor ----------------
   logic [7:0]  exp_words;
   logic [11:0] exp_data;

   initial begin
      exp_t e;
      exp_words = 8'd0;
      exp_data  = 12'h000;
      forever begin
         @(negedge clk);
         if (!reset) begin
            sb.delete();
            exp_words = 8'd0;
            exp_data  = 12'h000;
         end else begin
            chk("words_fwd", 32'(words_fwd), 32'(exp_words));
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("push", 32'(push), 32'(e.p));
               chk("data_out", 32'(data_out), 32'(e.d));
               exp_data  = e.d;
               exp_words = exp_words + 8'd1;
            end else begin
               chk("push_idle", 32'(push), 32'd0);
               chk("data_hold", 32'(data_out), 32'(exp_data));
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int guard;
      reset           = 1'b0;
      in_empty        = 4'b1111;
      fifo_out        = 12'h000;
      out_almost_full = 4'b0000;
      #1;
      reset_checks();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // Idle: nothing to serve, stays in ARB.
      cycle(8);

      // Single queue P0 with dest 0.
      fixed_en = 1'b1; fixed_word = 12'h296; keep_mask = 4'b0001;
      cycle(30);
      drain();

      // All queues busy, dest 2.
      fixed_word = 12'hAF0; keep_mask = 4'b1111;
      cycle(40);

      // Destination 2 held almost-full: every turn forfeits after STALL_LIM cycles.
      af_fixed = 4'b0100;
      cycle(60);
      // Intermittent almost-full: stalls interrupted by pops.
      af_fixed = 4'b0000; af_pct = 50;
      cycle(60);
      drain();

      // Early empty: P0 holds only 2 words, P1 waits behind it.
      qpush(0, 12'h401); qpush(0, 12'h802); qpush(1, 12'hC03);
      cycle(10);

      // Random traffic.
      fixed_en = 1'b0; rnd_fill = 30; af_pct = 10;
      cycle(3000);
      drain();

      // Mid-turn reset during a P1 turn.
      keep_mask = 4'b1111;
      guard = 0;
      while (!(m_serve && m_owner == 1 && m_left < QUOTA[1]) && guard < 100) begin
         cycle(1);
         guard++;
      end
      if (guard >= 100) begin
         n_checks++; n_err++;
         $display("FAIL p1_turn_timeout: got no P1 mid-turn within %0d cycles expected one", guard);
      end
      @(negedge clk);
      #3 reset = 1'b0;
      #1;
      reset_checks();
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      cycle(20);
      drain();

      // Long single-queue run so words_fwd wraps past 255.
      keep_mask = 4'b0001;
      cycle(400);
      drain();

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/arbitro_wrr.md
# arbitro_wrr

Weighted round-robin arbiter between four input FIFOs (P0–P3) and four output FIFOs, moving 12-bit words one per cycle. Each input queue gets a turn of up to QUOTAn words. Every word is routed to the output FIFO named by its destination field. A turn ends early when the queue runs empty or its head word stalls on a full destination. The block sits between the input FIFO bank (first-word-fall-through, externally muxed by `sel`) and the output FIFO bank.

## Interface
- WORD_W, 12, word width; destination field is bits [WORD_W-1:WORD_W-2]
- QUOTA0, 4, max words per turn for P0 (4-bit; 0 treated as 1)
- QUOTA1, 2, max words per turn for P1
- QUOTA2, 1, max words per turn for P2
- QUOTA3, 1, max words per turn for P3
- STALL_MAX, 8, consecutive stalled cycles before a turn is forfeited (4-bit)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-low reset
- in_empty  in  4  empty flags of input FIFOs P0–P3
- fifo_out  in  WORD_W  head word of the input FIFO selected by `sel`, valid in the same cycle
- out_almost_full  in  4  almost-full flags of output FIFOs 0–3
- sel  out  2  index of the queue being served
- pop  out  4  one-hot pop to input FIFOs; combinational
- push  out  4  one-hot push to output FIFOs; registered
- data_out  out  WORD_W  word written to output FIFOs; registered
- words_fwd  out  8  count of words forwarded; wraps

## Operation
- State machine: ARB, SERVE. Internal registers: `ptr` (2 bits), `q` (2 bits), `quota_cnt` (4 bits), `stall_cnt` (4 bits).
- ARB behaviour:
  - `pop` = 0.
  - Search for a non-empty queue, starting at `ptr` and wrapping modulo 4.
  - If one is found: set q = that index, sel = q, load quota_cnt with QUOTAq (0 → 1), clear stall_cnt, and go to SERVE.
  - If none is found (in_empty = 4'b1111), stay in ARB.
- SERVE, per cycle, with dest = fifo_out[11:10]:
  - If in_empty[q] = 1: no pop. Next state ARB, ptr = q+1.
  - Else if out_almost_full[dest] = 1: no pop and stall_cnt += 1. When stall_cnt reaches STALL_MAX-1 in this cycle, next state ARB, ptr = q+1. quota_cnt is unchanged.
  - Otherwise: pop[q] = 1, stall_cnt = 0, quota_cnt -= 1. When quota_cnt was 1, next state ARB, ptr = q+1.
- Forwarding:
  - When pop[q] is issued, the next cycle has push = one-hot(dest) and data_out = the popped word.
  - When no pop is issued, the next cycle has push = 0 and data_out holds its last value.
- words_fwd increments in every cycle where push ≠ 0, and wraps 255 → 0.
- `sel` holds its last value in ARB. Only one bit of `pop` and one bit of `push` is ever high.

## Timing
- Reset (reset = 0) acts immediately, without waiting for clk:
  - state = ARB, ptr = 0, q = 0, sel = 0
  - pop = 0, push = 0, data_out = 0, words_fwd = 0
  - quota_cnt = 0, stall_cnt = 0
- If reset arrives mid-turn, the turn is abandoned and any word in flight is not pushed. After release, arbitration restarts at P0.
- Pop latency: 0 cycles from the inputs. `pop` is combinational from state, in_empty, and out_almost_full[dest].
- Push latency: exactly 1 cycle after the pop.
- Turn overhead: 1 ARB cycle, with no pop, between consecutive turns.
- Back-to-back pops within a turn happen every cycle while the queue stays non-empty and unstalled.
- Simultaneous events in one SERVE cycle follow this priority: empty > stall > pop.
- A queue that empties exactly on its last-quota pop exits via the quota rule; there is no extra cycle.
- If only one queue is non-empty, it is re-granted after each ARB cycle.

## Test plan
- Reset and idle:
  - Stimulus: reset low for 2 cycles, then high, with in_empty = 4'b1111.
  - Response: pop = 0, push = 0, data_out = 0, words_fwd = 0, and the block stays in ARB.
- Single queue:
  - Stimulus: in_empty = 4'b1110, fifo_out = 12'h296 (dest 0).
  - Response: pop = 4'b0001 for 4 cycles, push = 4'b0001 one cycle after each, 1 ARB cycle, then P0 is re-granted. words_fwd = 4 after the first turn.
- All queues busy:
  - Stimulus: in_empty = 4'b0000, fifo_out = 12'hAF0 (dest 2).
  - Response: grants P0×4, P1×2, P2×1, P3×1, each separated by one ARB cycle, then P0 again. push = 4'b0100 throughout.
- Stall forfeit:
  - Stimulus: P2 served with dest 2 and out_almost_full = 4'b0100 held.
  - Response: pop = 0 for 8 cycles, then ARB and P3 is granted. Releasing almost_full mid-stall lets the pop resume and clears stall_cnt.
- Early empty:
  - Stimulus: P0 turn with QUOTA0 = 4 and in_empty[0] rising after 2 pops.
  - Response: exactly 2 pushes, next cycle ARB, ptr = 1.
- Mid-operation reset and counter wrap:
  - Stimulus: reset pulsed low during a P1 turn.
  - Response: pop, push, and data_out go to 0 at once. After release P0 is granted first.
  - Stimulus: 256 forwarded words.
  - Response: words_fwd returns to 0.
